// File: rtl/pc_ctrl_pkg.sv
// Shared decode constants for the fetch/decode PC path: next-PC op codes,
// comparator codes and the default reset/IM bounds.
package pc_ctrl_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned NPC_W   = 2;
  localparam int unsigned CMP_W   = 3;

  localparam logic [NPC_W-1:0] NPC_PC4    = 2'b00;
  localparam logic [NPC_W-1:0] NPC_BRANCH = 2'b01;
  localparam logic [NPC_W-1:0] NPC_J      = 2'b10;
  localparam logic [NPC_W-1:0] NPC_JR     = 2'b11;

  localparam logic [CMP_W-1:0] CMP_EQ  = 3'd0;
  localparam logic [CMP_W-1:0] CMP_NE  = 3'd1;
  localparam logic [CMP_W-1:0] CMP_LEZ = 3'd2;
  localparam logic [CMP_W-1:0] CMP_GTZ = 3'd3;
  localparam logic [CMP_W-1:0] CMP_LTZ = 3'd4;
  localparam logic [CMP_W-1:0] CMP_GEZ = 3'd5;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [XLEN-1:0] IM_TOP_DEF   = 32'h0000_6ffc;

  // Word-offset branch target relative to the delay-slot address, modulo 2^32.
  function automatic logic [XLEN-1:0] branch_target(input logic [XLEN-1:0] pc,
                                                    input logic [15:0]     imm16);
    return pc + XLEN'(4) + {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/pc_ctrl_npc_target.sv
// Combinational control-transfer target and redirect decision from D-stage controls.
module npc_target
  import pc_ctrl_pkg::*;
(
  input  logic [XLEN-1:0]  d_pc,
  input  logic             d_valid,
  input  logic [NPC_W-1:0] npc_op,
  input  logic             cmp_flag,
  input  logic [15:0]      imm16,
  input  logic [25:0]      imm26,
  input  logic [XLEN-1:0]  gpr_rs,
  output logic [XLEN-1:0]  target_c,
  output logic             redirect_c
);

  always_comb begin
    target_c   = branch_target(d_pc, imm16);
    redirect_c = 1'b0;
    case (npc_op)
      NPC_BRANCH: redirect_c = d_valid & cmp_flag;
      NPC_J: begin
        target_c   = {d_pc[31:28], imm26, 2'b00};
        redirect_c = d_valid;
      end
      NPC_JR: begin
        target_c   = gpr_rs;
        redirect_c = d_valid;
      end
      default: redirect_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_ctrl.sv
// F/D program-counter registers with delay-slot semantics and optional branch
// statistics counters (enabled by defining NPC_STAT_EN).
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] IM_TOP   = IM_TOP_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_op,
  input  logic        cmp_flag,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] gpr_rs,
  output logic [31:0] F_pc,
  output logic [31:0] D_pc,
  output logic [31:0] D_pc8,
  output logic        D_valid,
  output logic        redirect,
  output logic        adel_f,
  output logic [31:0] br_cnt,
  output logic [31:0] br_taken_cnt
);

  logic [XLEN-1:0] f_pc_q, f_pc_d;
  logic [XLEN-1:0] d_pc_q, d_pc_d;
  logic [XLEN-1:0] d_pc8_q, d_pc8_d;
  logic            d_valid_q, d_valid_d;
  logic [XLEN-1:0] target_c;
  logic            redirect_c;

  npc_target u_npc_target (
    .d_pc       (d_pc_q),
    .d_valid    (d_valid_q),
    .npc_op     (npc_op),
    .cmp_flag   (cmp_flag),
    .imm16      (imm16),
    .imm26      (imm26),
    .gpr_rs     (gpr_rs),
    .target_c   (target_c),
    .redirect_c (redirect_c)
  );

  // The fetched instruction always advances to D, so delay slots are never squashed.
  always_comb begin
    f_pc_d    = f_pc_q;
    d_pc_d    = d_pc_q;
    d_pc8_d   = d_pc8_q;
    d_valid_d = d_valid_q;
    if (!stall) begin
      f_pc_d    = redirect_c ? target_c : f_pc_q + XLEN'(4);
      d_pc_d    = f_pc_q;
      d_pc8_d   = f_pc_q + XLEN'(8);
      d_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_pc_q    <= RESET_PC;
      d_pc_q    <= RESET_PC;
      d_pc8_q   <= RESET_PC + XLEN'(8);
      d_valid_q <= 1'b0;
    end else begin
      f_pc_q    <= f_pc_d;
      d_pc_q    <= d_pc_d;
      d_pc8_q   <= d_pc8_d;
      d_valid_q <= d_valid_d;
    end
  end

  assign F_pc     = f_pc_q;
  assign D_pc     = d_pc_q;
  assign D_pc8    = d_pc8_q;
  assign D_valid  = d_valid_q;
  assign redirect = redirect_c;
  assign adel_f   = (f_pc_q[1:0] != 2'b00) || (f_pc_q < RESET_PC) || (f_pc_q > IM_TOP);

`ifdef NPC_STAT_EN
  logic [XLEN-1:0] br_cnt_q, br_cnt_d;
  logic [XLEN-1:0] br_taken_cnt_q, br_taken_cnt_d;
  logic            br_ev_c;

  assign br_ev_c = !stall && d_valid_q && (npc_op == NPC_BRANCH);

  // Saturating event counters.
  always_comb begin
    br_cnt_d       = br_cnt_q;
    br_taken_cnt_d = br_taken_cnt_q;
    if (br_ev_c && (br_cnt_q != '1)) br_cnt_d = br_cnt_q + XLEN'(1);
    if (br_ev_c && cmp_flag && (br_taken_cnt_q != '1)) br_taken_cnt_d = br_taken_cnt_q + XLEN'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      br_cnt_q       <= '0;
      br_taken_cnt_q <= '0;
    end else begin
      br_cnt_q       <= br_cnt_d;
      br_taken_cnt_q <= br_taken_cnt_d;
    end
  end

  assign br_cnt       = br_cnt_q;
  assign br_taken_cnt = br_taken_cnt_q;
`else
  assign br_cnt       = '0;
  assign br_taken_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed self-checking bench for pc_ctrl; branch-count expectations follow NPC_STAT_EN.
module tb_pc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  npc_op;
  logic        cmp_flag;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] gpr_rs;
  logic [31:0] F_pc, D_pc, D_pc8;
  logic        D_valid, redirect, adel_f;
  logic [31:0] br_cnt, br_taken_cnt;

  int total = 0;
  int bad   = 0;

`ifdef NPC_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  pc_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .npc_op       (npc_op),
    .cmp_flag     (cmp_flag),
    .imm16        (imm16),
    .imm26        (imm26),
    .gpr_rs       (gpr_rs),
    .F_pc         (F_pc),
    .D_pc         (D_pc),
    .D_pc8        (D_pc8),
    .D_valid      (D_valid),
    .redirect     (redirect),
    .adel_f       (adel_f),
    .br_cnt       (br_cnt),
    .br_taken_cnt (br_taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall    = 1'b0;
    npc_op   = 2'b00;
    cmp_flag = 1'b0;
    imm16    = 16'h0;
    imm26    = 26'h0;
    gpr_rs   = 32'h0;
  endtask

  // Reset then advance n free-running edges: D_pc = 3000 + 4*(n-1), F_pc = 3000 + 4*n.
  task automatic reset_and_run(input int n);
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    idle_inputs();
    npc_op = 2'b10;
    imm26  = 26'h0000c10;
    reset  = 1'b1;
    step();
    reset = 1'b0;
    total++; if (F_pc !== 32'h3000) begin bad++; $display("FAIL reset_f_pc got=%h exp=%h", F_pc, 32'h3000); end
    total++; if (D_pc !== 32'h3000) begin bad++; $display("FAIL reset_d_pc got=%h exp=%h", D_pc, 32'h3000); end
    total++; if (D_pc8 !== 32'h3008) begin bad++; $display("FAIL reset_d_pc8 got=%h exp=%h", D_pc8, 32'h3008); end
    total++; if (D_valid !== 1'b0) begin bad++; $display("FAIL reset_d_valid got=%b exp=0", D_valid); end
    total++; if (redirect !== 1'b0) begin bad++; $display("FAIL reset_redirect got=%b exp=0", redirect); end
    total++; if (adel_f !== 1'b0) begin bad++; $display("FAIL reset_adel got=%b exp=0", adel_f); end
    total++; if (br_cnt !== 32'h0 || br_taken_cnt !== 32'h0) begin
      bad++; $display("FAIL reset_cnt got=%h/%h exp=0/0", br_cnt, br_taken_cnt);
    end
    // J presented with D_valid=0 must not redirect.
    step();
    total++; if (F_pc !== 32'h3004) begin bad++; $display("FAIL reset_ignore_j got=%h exp=%h", F_pc, 32'h3004); end
    idle_inputs();
  endtask

  task automatic test_free_run();
    logic [31:0] exp_f, exp_d;
    reset_and_run(0);
    for (int i = 1; i <= 3; i++) begin
      step();
      exp_f = 32'h3000 + 32'(4 * i);
      exp_d = 32'h3000 + 32'(4 * (i - 1));
      total++; if (F_pc !== exp_f) begin bad++; $display("FAIL free_f_pc[%0d] got=%h exp=%h", i, F_pc, exp_f); end
      total++; if (D_pc !== exp_d) begin bad++; $display("FAIL free_d_pc[%0d] got=%h exp=%h", i, D_pc, exp_d); end
      total++; if (D_valid !== 1'b1) begin bad++; $display("FAIL free_d_valid[%0d] got=%b exp=1", i, D_valid); end
    end
  endtask

  task automatic test_branch();
    reset_and_run(5);
    total++; if (D_pc !== 32'h3010) begin bad++; $display("FAIL br_setup_d_pc got=%h exp=%h", D_pc, 32'h3010); end
    npc_op = 2'b01; cmp_flag = 1'b1; imm16 = 16'hfffc;
    #1;
    total++; if (redirect !== 1'b1) begin bad++; $display("FAIL br_taken_redirect got=%b exp=1", redirect); end
    step();
    total++; if (F_pc !== 32'h3004) begin bad++; $display("FAIL br_taken_f_pc got=%h exp=%h", F_pc, 32'h3004); end
    total++; if (D_pc !== 32'h3014) begin bad++; $display("FAIL br_delay_slot got=%h exp=%h", D_pc, 32'h3014); end
    total++; if (br_cnt !== (STAT ? 32'd1 : 32'd0) || br_taken_cnt !== (STAT ? 32'd1 : 32'd0)) begin
      bad++; $display("FAIL br_taken_cnt got=%h/%h exp=%h/%h", br_cnt, br_taken_cnt,
                      STAT ? 32'd1 : 32'd0, STAT ? 32'd1 : 32'd0);
    end
    // Not taken: sequential fetch, only br_cnt advances.
    cmp_flag = 1'b0;
    #1;
    total++; if (redirect !== 1'b0) begin bad++; $display("FAIL br_nt_redirect got=%b exp=0", redirect); end
    step();
    total++; if (F_pc !== 32'h3008) begin bad++; $display("FAIL br_nt_f_pc got=%h exp=%h", F_pc, 32'h3008); end
    total++; if (br_cnt !== (STAT ? 32'd2 : 32'd0) || br_taken_cnt !== (STAT ? 32'd1 : 32'd0)) begin
      bad++; $display("FAIL br_nt_cnt got=%h/%h exp=%h/%h", br_cnt, br_taken_cnt,
                      STAT ? 32'd2 : 32'd0, STAT ? 32'd1 : 32'd0);
    end
    // Stalled branch edge is not counted.
    cmp_flag = 1'b1; stall = 1'b1;
    step();
    total++; if (br_cnt !== (STAT ? 32'd2 : 32'd0) || F_pc !== 32'h3008) begin
      bad++; $display("FAIL br_stall_hold got=%h/%h exp=%h/%h", br_cnt, F_pc, STAT ? 32'd2 : 32'd0, 32'h3008);
    end
    idle_inputs();
  endtask

  task automatic test_jr_stall();
    reset_and_run(2);
    npc_op = 2'b11; gpr_rs = 32'h3002; stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (F_pc !== 32'h3008 || D_pc !== 32'h3004) begin
        bad++; $display("FAIL jr_stall_hold[%0d] got=%h/%h exp=%h/%h", i, F_pc, D_pc, 32'h3008, 32'h3004);
      end
    end
    stall = 1'b0;
    step();
    total++; if (F_pc !== 32'h3002) begin bad++; $display("FAIL jr_target got=%h exp=%h", F_pc, 32'h3002); end
    total++; if (adel_f !== 1'b1) begin bad++; $display("FAIL jr_adel got=%b exp=1", adel_f); end
    total++; if (D_pc !== 32'h3008) begin bad++; $display("FAIL jr_delay_slot got=%h exp=%h", D_pc, 32'h3008); end
    idle_inputs();
  endtask

  task automatic test_j();
    reset_and_run(9);
    npc_op = 2'b10; imm26 = 26'h0000c10;
    #1;
    total++; if (D_pc !== 32'h3020) begin bad++; $display("FAIL j_setup_d_pc got=%h exp=%h", D_pc, 32'h3020); end
    total++; if (D_pc8 !== 32'h3028) begin bad++; $display("FAIL j_d_pc8 got=%h exp=%h", D_pc8, 32'h3028); end
    step();
    total++; if (F_pc !== 32'h3040) begin bad++; $display("FAIL j_target got=%h exp=%h", F_pc, 32'h3040); end
    idle_inputs();
  endtask

  task automatic test_reset_during_stall();
    reset_and_run(3);
    npc_op = 2'b01; cmp_flag = 1'b1; step();
    npc_op = 2'b11; gpr_rs = 32'h5000; stall = 1'b1;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (F_pc !== 32'h3000 || D_valid !== 1'b0) begin
      bad++; $display("FAIL rst_stall_state got=%h/%b exp=%h/0", F_pc, D_valid, 32'h3000);
    end
    total++; if (br_cnt !== 32'h0 || br_taken_cnt !== 32'h0) begin
      bad++; $display("FAIL rst_stall_cnt got=%h/%h exp=0/0", br_cnt, br_taken_cnt);
    end
    total++; if (redirect !== 1'b0) begin bad++; $display("FAIL rst_stall_redirect got=%b exp=0", redirect); end
    stall = 1'b0;
    step();
    total++; if (F_pc !== 32'h3004) begin bad++; $display("FAIL rst_stall_next got=%h exp=%h", F_pc, 32'h3004); end
    idle_inputs();
  endtask

  task automatic test_wrap();
    reset_and_run(1);
    npc_op = 2'b11; gpr_rs = 32'hffff_fffc;
    step();
    total++; if (F_pc !== 32'hffff_fffc || adel_f !== 1'b1) begin
      bad++; $display("FAIL wrap_top got=%h/%b exp=%h/1", F_pc, adel_f, 32'hffff_fffc);
    end
    npc_op = 2'b00;
    step();
    total++; if (F_pc !== 32'h0 || adel_f !== 1'b1) begin
      bad++; $display("FAIL wrap_zero got=%h/%b exp=%h/1", F_pc, adel_f, 32'h0);
    end
    total++; if (D_pc !== 32'hffff_fffc || D_pc8 !== 32'h4) begin
      bad++; $display("FAIL wrap_d got=%h/%h exp=%h/%h", D_pc, D_pc8, 32'hffff_fffc, 32'h4);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    #1;
    test_reset();
    test_free_run();
    test_branch();
    test_jr_stall();
    test_j();
    test_reset_during_stall();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_3000, first fetch address after reset.
REQ-002 Parameter: IM_TOP, default 32'h0000_6ffc, highest legal instruction address.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hazard-unit stall of F and D; freezes all PC state.
REQ-006 npc_op  input  2  D-stage control: PC4=00, BRANCH=01, J=10, JR=11.
REQ-007 cmp_flag  input  1  branch-taken flag from the D-stage comparator; used only when npc_op=BRANCH.
REQ-008 imm16  input  16  D-stage branch offset in words.
REQ-009 imm26  input  26  D-stage jump index.
REQ-010 gpr_rs  input  32  forwarded rs value, the jr target.
REQ-011 F_pc  output  32  current fetch address to IM.
REQ-012 D_pc  output  32  PC of the instruction in D.
REQ-013 D_pc8  output  32  D_pc+8, the link address.
REQ-014 D_valid  output  1  D holds a real instruction, not a reset bubble.
REQ-015 redirect  output  1  combinational; the next F_pc is a control-transfer target.
REQ-016 adel_f  output  1  combinational; F_pc misaligned or outside [RESET_PC, IM_TOP].

Function
REQ-017 Branch target SHALL be D_pc+4+(sign-extended imm16 shifted left 2), computed with modulo-2^32 wrap.
REQ-018 J target SHALL be {D_pc[31:28], imm26, 2'b00}; JR target SHALL be gpr_rs unmodified.
REQ-019 redirect SHALL be D_valid and (npc_op=J, or npc_op=JR, or npc_op=BRANCH with cmp_flag=1).
REQ-020 On a non-stalled edge, F_pc SHALL load the target when redirect=1, otherwise F_pc+4.
REQ-021 On a non-stalled edge, D_pc SHALL load the old F_pc and D_valid SHALL be set to 1.
REQ-022 The instruction fetched in the cycle a transfer resolves in D SHALL advance to D as the delay slot; the block SHALL never squash it.
REQ-023 With stall=1, F_pc, D_pc and D_valid SHALL hold, and any redirect SHALL be taken only on the first non-stalled edge.
REQ-024 npc_op, cmp_flag, imm16, imm26 and gpr_rs SHALL be ignored while D_valid=0.
REQ-025 A misaligned JR target SHALL be loaded as given, and adel_f SHALL flag it in F; the block SHALL not correct it.
REQ-026 F_pc+4 SHALL wrap modulo 2^32 with no other side effect.

Reset
REQ-027 On a reset edge, F_pc and D_pc SHALL be RESET_PC, D_valid 0, and all counters 0; reset SHALL override stall and redirect.
REQ-028 In the cycle after reset, redirect SHALL be 0 and D_pc8 SHALL be RESET_PC+8.

Configuration
REQ-029 With NPC_STAT_EN defined, the block SHALL provide two 32-bit outputs, br_cnt and br_taken_cnt.
REQ-030 br_cnt SHALL count non-stalled edges with D_valid=1 and npc_op=BRANCH.
REQ-031 br_taken_cnt SHALL count the subset of br_cnt edges with cmp_flag=1.
REQ-032 Both counters SHALL saturate at 32'hffff_ffff.
REQ-033 Without NPC_STAT_EN, br_cnt and br_taken_cnt SHALL remain present and tied to 0, and no counter flops SHALL exist.

Structure
REQ-034 NPC_PC4/NPC_BRANCH/NPC_J/NPC_JR codes and the reset-PC constant SHALL live in the shared def header next to the CMP codes.
REQ-035 Target selection (REQ-017..019) SHALL be a combinational sub-module npc_target; pc_ctrl SHALL hold only the registers and counters.

Verification
REQ-036 Reset, then 3 free-running cycles -> F_pc 3000, 3004, 3008, 300c; D_pc 3000, 3004, 3008 from the second cycle; D_valid=1 after the first edge.
REQ-037 D_pc=3010, BRANCH, cmp_flag=1, imm16=16'hfffc -> redirect=1; next F_pc=3004 (3014-16); delay slot 3014 enters D.
REQ-038 Same as REQ-037 with cmp_flag=0 -> redirect=0; next F_pc=F_pc+4; br_cnt+1 and br_taken_cnt+0 when NPC_STAT_EN is defined.
REQ-039 JR with gpr_rs=3002, stall=1 for 2 cycles -> F_pc held for 2 cycles, then F_pc=3002 and adel_f=1.
REQ-040 J with imm26=26'h0000c10, D_pc=3020 -> next F_pc=3040; D_pc8=3028.
REQ-041 Assert reset during a stalled JR -> F_pc=3000, D_valid=0, counters 0, no redirect on the following edge.
